frame_scheduler: RTL and testbench

FRAME_SCHEDULER -- requirements
Module: frame_scheduler

---
 rtl/frame_scheduler.sv | 156 +++++++++++++++
 tb/tb_frame_scheduler.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_scheduler.sv
// Raster-order pixel scheduler for an HLS ap_ctrl_hs core, with a small result FIFO.
// FRAME mode streams a whole frame; STEP mode releases one pixel per start edge.
module frame_scheduler #(
   parameter int unsigned X_BITS     = 8,
   parameter int unsigned Y_BITS     = 8,
   parameter int unsigned COORD_W    = 16,
   parameter int unsigned PIX_W      = 24,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               abort,
   input  logic               mode_step,
   input  logic [X_BITS-1:0]  width_m1,
   input  logic [Y_BITS-1:0]  height_m1,
   output logic               core_start,
   input  logic               core_ready,
   input  logic               core_done,
   input  logic               core_idle,
   input  logic [PIX_W-1:0]   core_return,
   output logic [COORD_W-1:0] core_x,
   output logic [COORD_W-1:0] core_y,
   output logic               out_valid,
   output logic [PIX_W-1:0]   out_data,
   output logic               out_last,
   input  logic               out_ready,
   output logic               busy,
   output logic               frame_done
);

   localparam int unsigned AW   = $clog2(FIFO_DEPTH);
   localparam int unsigned CntW = AW + 1;
   localparam logic [AW:0] DepthCnt = CntW'(FIFO_DEPTH);

   typedef enum logic [2:0] {StIdle, StIssue, StWait, StAdvance, StHold, StDrain} state_e;

   state_e            state_q;
   logic              start_q, abort_q, mode_q, last_q, frame_done_q;
   logic [X_BITS-1:0] x_q, w_q;
   logic [Y_BITS-1:0] y_q, h_q;
   logic [PIX_W:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0]     wr_q, rd_q;
   logic [AW:0]       cnt_q;
   logic              start_edge, at_end, push, pop, push_last;

   assign start_edge = start & ~start_q;
   assign at_end     = (x_q == w_q) && (y_q == h_q);

   // Abort suppresses the request in the same cycle so no new pixel is launched.
   assign core_start = (state_q == StIssue) && (cnt_q < DepthCnt) && core_idle && !abort;

   assign push = ((state_q == StIssue) && core_start && core_ready && core_done) ||
                 ((state_q == StWait) && core_done);
   assign push_last = at_end || abort_q || abort;
   assign pop       = (cnt_q != '0) && out_ready;

   assign out_valid  = (cnt_q != '0);
   assign out_data   = mem_q[rd_q][PIX_W-1:0];
   assign out_last   = mem_q[rd_q][PIX_W] & out_valid;
   assign core_x     = COORD_W'(x_q);
   assign core_y     = COORD_W'(y_q);
   assign busy       = (state_q != StIdle);
   assign frame_done = frame_done_q;

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_q] <= {push_last, core_return};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StIdle;
         start_q      <= 1'b0;
         abort_q      <= 1'b0;
         mode_q       <= 1'b0;
         last_q       <= 1'b0;
         frame_done_q <= 1'b0;
         x_q          <= '0;
         y_q          <= '0;
         w_q          <= '0;
         h_q          <= '0;
         wr_q         <= '0;
         rd_q         <= '0;
         cnt_q        <= '0;
      end else begin
         start_q      <= start;
         frame_done_q <= 1'b0;
         if (push) wr_q <= wr_q + AW'(1);
         if (pop)  rd_q <= rd_q + AW'(1);
         case ({push, pop})
            2'b10:   cnt_q <= cnt_q + CntW'(1);
            2'b01:   cnt_q <= cnt_q - CntW'(1);
            default: cnt_q <= cnt_q;
         endcase

         case (state_q)
            StIdle: begin
               if (start_edge) begin
                  w_q     <= width_m1;
                  h_q     <= height_m1;
                  mode_q  <= mode_step;
                  x_q     <= '0;
                  y_q     <= '0;
                  abort_q <= 1'b0;
                  state_q <= StIssue;
               end
            end
            StIssue: begin
               if (abort) begin
                  state_q <= StDrain;
               end else if (core_start && core_ready) begin
                  last_q  <= push_last;
                  state_q <= core_done ? StAdvance : StWait;
               end
            end
            StWait: begin
               if (abort) abort_q <= 1'b1;
               if (core_done) begin
                  last_q  <= push_last;
                  state_q <= StAdvance;
               end
            end
            StAdvance: begin
               if (last_q || abort) begin
                  state_q <= StDrain;
               end else begin
                  if (x_q == w_q) begin
                     x_q <= '0;
                     y_q <= y_q + Y_BITS'(1);
                  end else begin
                     x_q <= x_q + X_BITS'(1);
                  end
                  state_q <= mode_q ? StHold : StIssue;
               end
            end
            StHold: begin
               if (abort) begin
                  state_q <= StDrain;
               end else if (start_edge) begin
                  state_q <= StIssue;
               end
            end
            StDrain: begin
               if (cnt_q == '0) begin
                  frame_done_q <= 1'b1;
                  state_q      <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_frame_scheduler.sv
// Bench for frame_scheduler: behavioural HLS core plus a raster-order pixel scoreboard.
module tb_frame_scheduler;

   logic        clk = 1'b0;
   logic        reset, start, abort, mode_step, out_ready;
   logic [7:0]  width_m1, height_m1;
   logic        core_start, core_ready, core_done, core_idle;
   logic [23:0] core_return, out_data;
   logic [15:0] core_x, core_y;
   logic        out_valid, out_last, busy, frame_done;

   int          n_checks = 0;
   int          n_fail = 0;
   int          fd_cnt = 0;
   int          hs_cnt = 0;
   int unsigned core_lat = 5;
   logic [7:0]  salt = 8'h00;
   logic [24:0] exp_q[$];

   // Behavioural core: accepts when idle, answers core_lat cycles after the handshake.
   logic        busy_c = 1'b0;
   int unsigned cnt_c = 0;
   logic [15:0] cap_x = '0, cap_y = '0;

   frame_scheduler dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort), .mode_step(mode_step),
      .width_m1(width_m1), .height_m1(height_m1), .core_start(core_start),
      .core_ready(core_ready), .core_done(core_done), .core_idle(core_idle),
      .core_return(core_return), .core_x(core_x), .core_y(core_y), .out_valid(out_valid),
      .out_data(out_data), .out_last(out_last), .out_ready(out_ready), .busy(busy),
      .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   function automatic logic [23:0] pix(input logic [15:0] x, input logic [15:0] y);
      return {salt, x[7:0], y[7:0]};
   endfunction

   assign core_idle   = !busy_c;
   assign core_ready  = core_start && !busy_c;
   assign core_done   = (busy_c && cnt_c == 0) || (core_lat == 0 && core_start && core_ready);
   assign core_return = busy_c ? pix(cap_x, cap_y) : pix(core_x, core_y);

   always @(posedge clk) begin
      if (busy_c) begin
         if (cnt_c == 0) busy_c <= 1'b0;
         else            cnt_c  <= cnt_c - 1;
      end else if (core_start && core_ready && core_lat != 0) begin
         busy_c <= 1'b1;
         cnt_c  <= core_lat - 1;
         cap_x  <= core_x;
         cap_y  <= core_y;
      end
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Monitor: scoreboard pops, count handshakes and frame_done pulses.
   initial begin
      logic [24:0] e;
      forever begin
         @(negedge clk);
         if (!reset) begin
            if (out_valid && out_ready) begin
               check_eq("pop_expected", 64'(exp_q.size() != 0), 64'd1);
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  check_eq("out_data", 64'(out_data), 64'(e[23:0]));
                  check_eq("out_last", 64'(out_last), 64'(e[24]));
               end
            end
            if (core_start && core_ready) hs_cnt++;
            if (frame_done) fd_cnt++;
            if (core_done && busy_c && busy) begin
               check_eq("coord_x_stable", 64'(core_x), 64'(cap_x));
               check_eq("coord_y_stable", 64'(core_y), 64'(cap_y));
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push_exp(input int x, input int y, input logic last);
      exp_q.push_back({last, pix(16'(x), 16'(y))});
   endtask

   task automatic load_frame(input int w, input int h);
      for (int y = 0; y <= h; y++)
         for (int x = 0; x <= w; x++)
            push_exp(x, y, (x == w) && (y == h));
   endtask

   task automatic start_frame(input logic m, input int w, input int h);
      mode_step = m;
      width_m1  = 8'(w);
      height_m1 = 8'(h);
      start     = 1'b1;
      tick(1);
      start     = 1'b0;
   endtask

   task automatic wait_fd(input int target, input int budget);
      int n = 0;
      while (fd_cnt < target && n < budget) begin
         tick(1);
         n++;
      end
      check_eq("frame_done_seen", 64'(fd_cnt >= target), 64'd1);
   endtask

   task automatic wait_hs(input int target, input int budget);
      int n = 0;
      while (hs_cnt < target && n < budget) begin
         tick(1);
         n++;
      end
      check_eq("handshake_seen", 64'(hs_cnt >= target), 64'd1);
   endtask

   initial begin
      int base_fd, base_hs, w, h, n;
      reset = 1'b1; start = 1'b0; abort = 1'b0; mode_step = 1'b0;
      width_m1 = '0; height_m1 = '0; out_ready = 1'b1;
      tick(2);
      check_eq("rst_busy", 64'(busy), 64'd0);
      check_eq("rst_out_valid", 64'(out_valid), 64'd0);
      check_eq("rst_out_last", 64'(out_last), 64'd0);
      check_eq("rst_core_start", 64'(core_start), 64'd0);
      check_eq("rst_frame_done", 64'(frame_done), 64'd0);
      check_eq("rst_core_x", 64'(core_x), 64'd0);
      check_eq("rst_core_y", 64'(core_y), 64'd0);
      reset = 1'b0;
      tick(2);

      // 3x2 frame, latency 5, consumer always ready.
      salt = 8'h11; core_lat = 5; base_fd = fd_cnt; base_hs = hs_cnt;
      load_frame(2, 1);
      start_frame(1'b0, 2, 1);
      wait_fd(base_fd + 1, 500);
      tick(3);
      check_eq("f3x2_left", 64'(exp_q.size()), 64'd0);
      check_eq("f3x2_hs", 64'(hs_cnt - base_hs), 64'd6);
      check_eq("f3x2_fd_once", 64'(fd_cnt - base_fd), 64'd1);
      check_eq("f3x2_idle", 64'(busy), 64'd0);

      // Back-pressure: FIFO of 4 fills, then issue stalls until the consumer returns.
      salt = 8'h22; core_lat = 2; base_fd = fd_cnt; base_hs = hs_cnt;
      out_ready = 1'b0;
      load_frame(2, 1);
      start_frame(1'b0, 2, 1);
      tick(60);
      check_eq("bp_hs_stall", 64'(hs_cnt - base_hs), 64'd4);
      check_eq("bp_core_start", 64'(core_start), 64'd0);
      check_eq("bp_out_valid", 64'(out_valid), 64'd1);
      out_ready = 1'b1;
      wait_fd(base_fd + 1, 500);
      check_eq("bp_left", 64'(exp_q.size()), 64'd0);
      check_eq("bp_hs_total", 64'(hs_cnt - base_hs), 64'd6);

      // STEP mode 2x1: parks in HOLD after the first pixel.
      salt = 8'h33; core_lat = 3; base_fd = fd_cnt; base_hs = hs_cnt;
      load_frame(1, 0);
      start_frame(1'b1, 1, 0);
      tick(30);
      check_eq("step_hs_hold", 64'(hs_cnt - base_hs), 64'd1);
      check_eq("step_busy_hold", 64'(busy), 64'd1);
      check_eq("step_no_start", 64'(core_start), 64'd0);
      check_eq("step_one_out", 64'(exp_q.size()), 64'd1);
      start = 1'b1;
      tick(1);
      start = 1'b0;
      wait_fd(base_fd + 1, 200);
      check_eq("step_hs_total", 64'(hs_cnt - base_hs), 64'd2);
      check_eq("step_left", 64'(exp_q.size()), 64'd0);

      // Abort during WAIT of pixel (1,0) in a 4x4 frame.
      salt = 8'h44; core_lat = 5; base_fd = fd_cnt; base_hs = hs_cnt;
      push_exp(0, 0, 1'b0);
      push_exp(1, 0, 1'b1);
      start_frame(1'b0, 3, 3);
      wait_hs(base_hs + 2, 100);
      abort = 1'b1;
      tick(1);
      abort = 1'b0;
      wait_fd(base_fd + 1, 200);
      tick(20);
      check_eq("abort_hs", 64'(hs_cnt - base_hs), 64'd2);
      check_eq("abort_fd", 64'(fd_cnt - base_fd), 64'd1);
      check_eq("abort_left", 64'(exp_q.size()), 64'd0);

      // Single-cycle core, 1x1 frame.
      salt = 8'h55; core_lat = 0; base_fd = fd_cnt; base_hs = hs_cnt;
      load_frame(0, 0);
      start_frame(1'b0, 0, 0);
      wait_fd(base_fd + 1, 100);
      tick(2);
      check_eq("one_px_hs", 64'(hs_cnt - base_hs), 64'd1);
      check_eq("one_px_left", 64'(exp_q.size()), 64'd0);
      check_eq("one_px_idle", 64'(busy), 64'd0);

      // Reset in WAIT with two buffered results; the late core_done must vanish.
      salt = 8'h66; core_lat = 5; base_hs = hs_cnt;
      out_ready = 1'b0;
      start_frame(1'b0, 2, 1);
      wait_hs(base_hs + 3, 200);
      tick(1);
      check_eq("rst_mid_filled", 64'(out_valid), 64'd1);
      reset = 1'b1;
      tick(1);
      check_eq("rst_mid_out_valid", 64'(out_valid), 64'd0);
      check_eq("rst_mid_busy", 64'(busy), 64'd0);
      check_eq("rst_mid_core_start", 64'(core_start), 64'd0);
      reset = 1'b0;
      out_ready = 1'b1;
      tick(20);
      check_eq("rst_late_out_valid", 64'(out_valid), 64'd0);
      check_eq("rst_late_busy", 64'(busy), 64'd0);
      check_eq("rst_late_hs", 64'(hs_cnt - base_hs), 64'd3);

      // Random frames: random size, latency, mode, back-pressure and stray start edges.
      for (int f = 0; f < 10; f++) begin
         salt = 8'($urandom); core_lat = $urandom_range(0, 4);
         w = $urandom_range(0, 4); h = $urandom_range(0, 3);
         base_fd = fd_cnt; base_hs = hs_cnt;
         load_frame(w, h);
         start_frame(1'($urandom), w, h);
         n = 0;
         while (fd_cnt == base_fd && n < 3000) begin
            out_ready = ($urandom % 4) != 0;
            start     = busy && (($urandom % 3) == 0);
            tick(1);
            n++;
         end
         out_ready = 1'b1;
         start     = 1'b0;
         tick(3);
         check_eq("rnd_fd", 64'(fd_cnt - base_fd), 64'd1);
         check_eq("rnd_hs", 64'(hs_cnt - base_hs), 64'((w + 1) * (h + 1)));
         check_eq("rnd_left", 64'(exp_q.size()), 64'd0);
         exp_q.delete();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
